// File: rtl/keypad_scanner.sv
// 4x5 matrix keypad scanner: column drive, row synchronisation, per-scan
// key classification and a debounce FSM producing one newkey strobe per press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [4:0] col_n,
  output logic       newkey,
  output logic [4:0] keycode,
  output logic       keydown
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, RELEASE} state_t;

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       col_idx;
  logic [1:0]       acc_n;
  logic [4:0]       acc_code;
  state_t           state;
  logic [4:0]       cand;
  logic [CNT_W-1:0] cnt;

  logic             slot_end;
  logic             scan_end;
  logic [2:0]       hits;
  logic [4:0]       hit_code;
  logic [2:0]       sum_n;
  logic [1:0]       tot_n;
  logic [4:0]       tot_code;
  logic             single;
  logic             none;
  logic [CNT_W-1:0] cnt_inc;

  assign slot_end = (div_cnt == DIV_LAST);
  assign scan_end = slot_end && (col_idx == 3'd4);
  assign cnt_inc  = cnt + CNT_W'(1);

  // Keys seen in the current column, merged with the running scan tally (saturates at 2 = MULTI)
  always_comb begin
    hits     = 3'd0;
    hit_code = 5'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync[i]) begin
        hits     = hits + 3'd1;
        hit_code = 5'(5 * i) + 5'(col_idx);
      end
    end
    sum_n    = 3'(acc_n) + hits;
    tot_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    tot_code = (acc_n != 2'd0) ? acc_code : hit_code;
    single   = (tot_n == 2'd1);
    none     = (tot_n == 2'd0);
  end

  // Row synchroniser, column sequencer and per-scan accumulator
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      div_cnt  <= '0;
      col_idx  <= 3'd0;
      col_n    <= 5'b11110;
      acc_n    <= 2'd0;
      acc_code <= 5'd0;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
      if (slot_end) begin
        div_cnt <= '0;
        col_idx <= (col_idx == 3'd4) ? 3'd0 : col_idx + 3'd1;
        col_n   <= {col_n[3:0], col_n[4]};
        if (scan_end) begin
          acc_n    <= 2'd0;
          acc_code <= 5'd0;
        end else begin
          acc_n    <= tot_n;
          acc_code <= tot_code;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Debounce FSM, stepped once per full scan
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cand    <= 5'd0;
      cnt     <= '0;
      newkey  <= 1'b0;
      keycode <= 5'd0;
      keydown <= 1'b0;
    end else begin
      newkey <= 1'b0;
      if (scan_end) begin
        case (state)
          IDLE: begin
            if (single) begin
              if (DEBOUNCE == 1) begin
                state   <= PRESSED;
                newkey  <= 1'b1;
                keycode <= tot_code;
                keydown <= 1'b1;
              end else begin
                state <= CAND;
                cand  <= tot_code;
                cnt   <= CNT_W'(1);
              end
            end
          end
          CAND: begin
            if (single) begin
              if (tot_code != cand) begin
                cand <= tot_code;
                cnt  <= CNT_W'(1);
              end else if (cnt_inc == DB_MAX) begin
                state   <= PRESSED;
                newkey  <= 1'b1;
                keycode <= cand;
                keydown <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= IDLE;
            end
          end
          PRESSED: begin
            if (none) begin
              if (DEBOUNCE == 1) begin
                state   <= IDLE;
                keydown <= 1'b0;
              end else begin
                state <= RELEASE;
                cnt   <= CNT_W'(1);
              end
            end
          end
          RELEASE: begin
            if (!none) begin
              state <= PRESSED;
            end else if (cnt_inc == DB_MAX) begin
              state   <= IDLE;
              keydown <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a switch-matrix model (SCAN_DIV=4, DEBOUNCE=2).
module tb_keypad_scanner;

  localparam int unsigned SCAN = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row_n;
  logic [4:0]  col_n;
  logic        newkey;
  logic [4:0]  keycode;
  logic        keydown;
  logic [19:0] keys = 20'd0;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc;
  int nk_cycles;
  int last_pulse;
  int fall_cyc;
  int nk_code;
  int nk_kd_err;
  logic kd_q;

  typedef struct {
    logic [19:0] ka; int sa;
    logic [19:0] kb; int sb;
    logic [19:0] kc; int sc;
    int pulses; int code; int kd; int last; int fall;
  } vec_t;

  vec_t vecs[9];

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .row_n   (row_n),
    .col_n   (col_n),
    .newkey  (newkey),
    .keycode (keycode),
    .keydown (keydown)
  );

  // Pressed switch (i,j) pulls row i low while column j is driven low
  always_comb begin
    row_n = 4'hF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 5; j++)
        if (keys[5*i+j] && !col_n[j]) row_n[i] = 1'b0;
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Strobe/keydown observer; cyc here equals the index of the preceding edge
  always @(negedge clock or negedge reset) begin
    if (!reset) begin
      nk_cycles  <= 0;
      last_pulse <= 0;
      fall_cyc   <= 0;
      nk_code    <= 0;
      nk_kd_err  <= 0;
      kd_q       <= 1'b0;
    end else begin
      kd_q <= keydown;
      if (newkey) begin
        nk_cycles  <= nk_cycles + 1;
        last_pulse <= cyc;
        nk_code    <= int'(keycode);
        if (!keydown) nk_kd_err <= nk_kd_err + 1;
      end
      if (kd_q && !keydown) fall_cyc <= cyc;
    end
  end

  function automatic logic [19:0] k(input int c);
    logic [19:0] one;
    one = 20'd1;
    return one << c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input logic [19:0] mask);
    reset = 1'b0;
    keys  = mask;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] exp_col;
    logic [4:0] ones;

    //             ka          sa  kb          sb  kc       sc  pul code kd last fall
    vecs[0] = '{20'd0,        10, 20'd0,       0, 20'd0,    0,  0,  0,  0,  0,   0};
    vecs[1] = '{k(13),        10, 20'd0,       3, 20'd0,    0,  1, 13,  0, 40, 240};
    vecs[2] = '{k(5),          1, 20'd0,       3, 20'd0,    0,  0,  0,  0,  0,   0};
    vecs[3] = '{k(0) | k(6),   3, k(6),        3, 20'd0,    0,  1,  6,  1, 100,  0};
    vecs[4] = '{k(13),         3, 20'd0,       1, k(13),    3,  1, 13,  1, 40,   0};
    vecs[5] = '{k(2),          1, k(7),        2, 20'd0,    0,  1,  7,  1, 60,   0};
    vecs[6] = '{k(19),         2, 20'd0,       0, 20'd0,    0,  1, 19,  1, 40,   0};
    vecs[7] = '{k(4) | k(9),   3, 20'd0,       0, 20'd0,    0,  0,  0,  0,  0,   0};
    vecs[8] = '{k(13),         3, k(13) | k(0), 2, 20'd0,   2,  1, 13,  0, 40, 140};

    // Reset values, then the column walk
    reset = 1'b0;
    keys  = 20'd0;
    repeat (2) @(posedge clock);
    #1;
    check("rst col_n",   int'(col_n),   int'(5'b11110));
    check("rst newkey",  int'(newkey),  0);
    check("rst keycode", int'(keycode), 0);
    check("rst keydown", int'(keydown), 0);
    @(negedge clock);
    reset = 1'b1;
    ones  = 5'b11111;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clock);
      #1;
      exp_col = ones & ~(5'd1 << ((n / 4) % 5));
      check($sformatf("col_n edge %0d", n), int'(col_n), int'(exp_col));
    end

    for (int v = 0; v < 9; v++) begin
      apply_reset(vecs[v].ka);
      run(SCAN * vecs[v].sa);
      keys = vecs[v].kb;
      run(SCAN * vecs[v].sb);
      keys = vecs[v].kc;
      run(SCAN * vecs[v].sc);
      run(2);
      check($sformatf("v%0d pulses", v),     nk_cycles,       vecs[v].pulses);
      check($sformatf("v%0d keycode", v),    int'(keycode),   vecs[v].code);
      check($sformatf("v%0d keydown", v),    int'(keydown),   vecs[v].kd);
      check($sformatf("v%0d pulse_cyc", v),  last_pulse,      vecs[v].last);
      check($sformatf("v%0d fall_cyc", v),   fall_cyc,        vecs[v].fall);
      check($sformatf("v%0d strobe_code", v), nk_code,        vecs[v].pulses == 0 ? 0 : vecs[v].code);
      check($sformatf("v%0d kd_with_nk", v), nk_kd_err,       0);
    end

    // Reset while a candidate is being debounced, key held through reset
    apply_reset(k(13));
    run(60);
    keys = 20'd0;
    run(40);
    keys = k(4);
    run(20);
    check("pre-reset keycode", int'(keycode), 13);
    run(5);
    reset = 1'b0;
    #1;
    check("midrst col_n",   int'(col_n),   int'(5'b11110));
    check("midrst keycode", int'(keycode), 0);
    check("midrst keydown", int'(keydown), 0);
    check("midrst newkey",  int'(newkey),  0);
    @(negedge clock);
    reset = 1'b1;
    run(30);
    check("postrst early pulses", nk_cycles, 0);
    run(12);
    check("postrst pulses",    nk_cycles,     1);
    check("postrst pulse_cyc", last_pulse,    40);
    check("postrst keycode",   int'(keycode), 4);
    check("postrst keydown",   int'(keydown), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
